// File: rtl/car_cmd_uart_tx_pkg.sv
// Shared definitions for the car command UART transmitter: frame layout and FSM encoding.
// Latency: n/a (constants and a combinational packing helper).
// Backpressure: n/a.
package car_cmd_uart_tx_pkg;

   // Header marks a byte as a command, so an all-zero byte on the line is treated as noise
   localparam logic [1:0] CMD_HDR = 2'b01;

   // Bit positions of the command frame fields
   localparam int HDR_MSB = 7;
   localparam int HDR_LSB = 6;
   localparam int PD_POS  = 5;
   localparam int PP_POS  = 4;
   localparam int M_MSB   = 3;
   localparam int M_LSB   = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   function automatic logic [7:0] pack_cmd(input logic pd, input logic pp, input logic [3:0] m);
      logic [7:0] b;
      b = '0;
      b[HDR_MSB:HDR_LSB] = CMD_HDR;
      b[PD_POS]          = pd;
      b[PP_POS]          = pp;
      b[M_MSB:M_LSB]     = m;
      return b;
   endfunction

endpackage

// File: rtl/car_cmd_uart_tx_core.sv
// 8N1 UART serializer: start bit, 8 data bits LSB first, one stop bit, BIT_CYCLES clocks each.
// Latency: start seen in IDLE at cycle N drives the start bit at N+1; frame lasts 10*BIT_CYCLES.
// Backpressure: start is only accepted while busy is low; done pulses in the last stop-bit cycle.
module uart_tx_core
   import car_cmd_uart_tx_pkg::*;
#(
   parameter int BIT_CYCLES = 10
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int            CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (bit_cnt == CNT_LAST);

   // State register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: each non-idle state lasts whole bit periods
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = START;
         START:   if (bit_end) state_nxt = DATA;
         DATA:    if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
         STOP:    if (bit_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Baud counter reloads at every bit boundary; shifter loads on start and shifts after each data bit
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else if (state == IDLE) begin
         bit_cnt <= '0;
         bit_idx <= '0;
         if (start) shreg <= data;
      end else if (bit_end) begin
         bit_cnt <= '0;
         if (state == DATA) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end else begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // Outputs decoded from state so reset forces the line idle immediately
   always_comb begin
      tx   = 1'b1;
      busy = 1'b1;
      done = 1'b0;
      case (state)
         IDLE:    busy = 1'b0;
         START:   tx   = 1'b0;
         DATA:    tx   = shreg[0];
         STOP:    done = bit_end;
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: rtl/car_cmd_uart_tx.sv
// Sends one-byte car command frames on change, on pending barrier request, and on periodic refresh.
// Latency: trigger evaluated in IDLE at cycle N puts the start bit on tx at N+1.
// Backpressure: none upstream; inputs are levels/sticky flags re-evaluated each time the line is idle.
module car_cmd_uart_tx
   import car_cmd_uart_tx_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int BAUD           = 9600,
   parameter int REFRESH_CYCLES = 1_000_000
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic enable,
   input  logic turn_left,
   input  logic turn_right,
   input  logic move_forward,
   input  logic move_backward,
   input  logic place_barrier,
   input  logic destroy_barrier,
   output logic tx,
   output logic busy,
   output logic frame_sent
);

   localparam int            BIT_CYCLES  = CLK_HZ / BAUD;
   localparam int            RW          = $clog2(REFRESH_CYCLES + 1);
   localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYCLES);

   logic [3:0]    m;
   logic [3:0]    last_m;
   logic          pp;
   logic          pd;
   logic [RW-1:0] refresh_cnt;
   logic          trigger;
   logic          core_busy;
   logic [7:0]    frame_byte;

   // Motion nibble; contradictory pairs cancel, and an unpowered car commands stop
   always_comb begin
      m = '0;
      if (enable) begin
         m[0] = turn_left & ~turn_right;
         m[1] = turn_right & ~turn_left;
         m[2] = move_forward & ~move_backward;
         m[3] = move_backward & ~move_forward;
      end
   end

   assign trigger = !core_busy &&
                    ((m != last_m) || pp || pd || (enable && (refresh_cnt >= REFRESH_MAX)));

   assign frame_byte = pack_cmd(pd, pp, m);

   // Sticky barrier requests; a request arriving in the latch cycle survives for the next frame
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pp <= 1'b0;
         pd <= 1'b0;
      end else if (!enable) begin
         pp <= 1'b0;
         pd <= 1'b0;
      end else begin
         if (place_barrier)     pp <= 1'b1;
         else if (trigger)      pp <= 1'b0;
         if (destroy_barrier)   pd <= 1'b1;
         else if (trigger)      pd <= 1'b0;
      end
   end

   // Remember the motion nibble of the last frame for change detection
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)       last_m <= '0;
      else if (trigger) last_m <= m;
   end

   // Refresh timer restarts at each frame start and saturates at its limit
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)                         refresh_cnt <= '0;
      else if (trigger)                   refresh_cnt <= '0;
      else if (refresh_cnt < REFRESH_MAX) refresh_cnt <= refresh_cnt + 1'b1;
   end

   uart_tx_core #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_core (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .start   (trigger),
      .data    (frame_byte),
      .tx      (tx),
      .busy    (core_busy),
      .done    (frame_sent)
   );

   assign busy = core_busy;

endmodule

// File: tb/tb_car_cmd_uart_tx.sv
// Directed bench for car_cmd_uart_tx with BIT_CYCLES=10 and REFRESH_CYCLES=300.
// Latency: frames are decoded by sampling tx mid-bit over 100 cycles.
// Backpressure: n/a.
module tb_car_cmd_uart_tx;

   logic sys_clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic turn_left = 1'b0;
   logic turn_right = 1'b0;
   logic move_forward = 1'b0;
   logic move_backward = 1'b0;
   logic place_barrier = 1'b0;
   logic destroy_barrier = 1'b0;
   logic tx;
   logic busy;
   logic frame_sent;

   int vectors = 0;
   int miscompares = 0;

   always #5 sys_clk = ~sys_clk;

   car_cmd_uart_tx #(
      .CLK_HZ         (1000),
      .BAUD           (100),
      .REFRESH_CYCLES (300)
   ) dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .turn_left       (turn_left),
      .turn_right      (turn_right),
      .move_forward    (move_forward),
      .move_backward   (move_backward),
      .place_barrier   (place_barrier),
      .destroy_barrier (destroy_barrier),
      .tx              (tx),
      .busy            (busy),
      .frame_sent      (frame_sent)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Advance until tx goes low or the budget runs out; waited==max means no frame started
   task automatic wait_start(input int max, output int waited);
      waited = 0;
      while (tx !== 1'b0 && waited < max) begin
         step(1);
         waited++;
      end
   endtask

   // Entered in frame cycle 0; leaves in cycle 100 (first idle cycle after the frame)
   task automatic capture(input int pulse_at, input int drop_at, output logic [7:0] b,
                          output int fs_cnt, output int fs_pos, output logic shape_ok);
      b = '0;
      fs_cnt = 0;
      fs_pos = -1;
      shape_ok = 1'b1;
      for (int j = 0; j < 100; j++) begin
         if (frame_sent === 1'b1) begin
            fs_cnt++;
            fs_pos = j;
         end
         if (busy !== 1'b1) shape_ok = 1'b0;
         if (j < 10 && tx !== 1'b0) shape_ok = 1'b0;
         if (j >= 90 && tx !== 1'b1) shape_ok = 1'b0;
         if (j >= 10 && j < 90 && (j % 10) == 5) b[(j - 10) / 10] = tx;
         if (j == pulse_at) place_barrier = 1'b1;
         if (j == pulse_at + 1) place_barrier = 1'b0;
         if (j == drop_at) enable = 1'b0;
         step(1);
      end
   endtask

   task automatic test_reset();
      logic [7:0] b;
      int fs_cnt, fs_pos, w;
      logic ok;
      rst_n = 1'b0;
      step(3);
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got=%b want=1", tx); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
      vectors++; if (frame_sent !== 1'b0) begin miscompares++; $display("FAIL reset_frame_sent got=%b want=0", frame_sent); end
      enable = 1'b1;
      rst_n = 1'b1;
      wait_start(400, w);
      vectors++; if (w !== 301) begin miscompares++; $display("FAIL first_refresh_delay got=%0d want=301", w); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h40) begin miscompares++; $display("FAIL first_refresh_byte got=%h want=40", b); end
      vectors++; if (fs_cnt !== 1) begin miscompares++; $display("FAIL frame_sent_count got=%0d want=1", fs_cnt); end
      vectors++; if (fs_pos !== 99) begin miscompares++; $display("FAIL frame_sent_pos got=%0d want=99", fs_pos); end
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL frame_shape got=%b want=1", ok); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_frame got=%b want=0", busy); end
   endtask

   task automatic test_forward();
      logic [7:0] b;
      int fs_cnt, fs_pos, w;
      logic ok;
      move_forward = 1'b1;
      step(1);
      vectors++; if (tx !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL fwd_latency tx=%b busy=%b want tx=0 busy=1", tx, busy); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h44) begin miscompares++; $display("FAIL fwd_byte got=%h want=44", b); end
      vectors++; if (ok !== 1'b1 || fs_pos !== 99) begin miscompares++; $display("FAIL fwd_shape ok=%b fs_pos=%0d want 1/99", ok, fs_pos); end
      wait_start(250, w);
      vectors++; if (w !== 201) begin miscompares++; $display("FAIL fwd_refresh_delay got=%0d want=201", w); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h44) begin miscompares++; $display("FAIL fwd_refresh_byte got=%h want=44", b); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      int fs_cnt, fs_pos;
      logic ok;
      move_forward = 1'b0;
      turn_left = 1'b1;
      turn_right = 1'b1;
      move_backward = 1'b1;
      step(1);
      vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL b2b_gap tx=%b want=0", tx); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h48) begin miscompares++; $display("FAIL conflict_byte got=%h want=48", b); end
   endtask

   task automatic test_barrier();
      logic [7:0] b;
      int fs_cnt, fs_pos, w;
      logic ok;
      turn_left = 1'b0;
      turn_right = 1'b0;
      move_backward = 1'b0;
      step(1);
      vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL stop_cmd_start tx=%b want=0", tx); end
      capture(30, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h40) begin miscompares++; $display("FAIL barrier_inflight_byte got=%h want=40", b); end
      step(1);
      vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL barrier_start tx=%b want=0", tx); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h50) begin miscompares++; $display("FAIL barrier_byte got=%h want=50", b); end
      wait_start(250, w);
      vectors++; if (w !== 201) begin miscompares++; $display("FAIL barrier_refresh_delay got=%0d want=201", w); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h40) begin miscompares++; $display("FAIL barrier_refresh_byte got=%h want=40", b); end
   endtask

   task automatic test_power_off();
      logic [7:0] b;
      int fs_cnt, fs_pos, w;
      logic ok;
      move_forward = 1'b1;
      step(1);
      capture(-1, 40, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h44 || ok !== 1'b1) begin miscompares++; $display("FAIL pwroff_inflight byte=%h ok=%b want 44/1", b, ok); end
      step(1);
      vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL pwroff_stop_start tx=%b want=0", tx); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h40) begin miscompares++; $display("FAIL pwroff_stop_byte got=%h want=40", b); end
      wait_start(700, w);
      vectors++; if (w !== 700 || tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL pwroff_quiet waited=%0d tx=%b busy=%b want 700/1/0", w, tx, busy); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      int fs_cnt, fs_pos, w;
      logic ok;
      enable = 1'b1;
      step(1);
      vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_start tx=%b want=0", tx); end
      step(25);
      rst_n = 1'b0;
      #1;
      vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_async tx=%b busy=%b want 1/0", tx, busy); end
      move_forward = 1'b0;
      step(3);
      rst_n = 1'b1;
      wait_start(400, w);
      vectors++; if (w !== 301) begin miscompares++; $display("FAIL rstmid_refresh_delay got=%0d want=301", w); end
      capture(-1, -1, b, fs_cnt, fs_pos, ok);
      vectors++; if (b !== 8'h40 || fs_cnt !== 1) begin miscompares++; $display("FAIL rstmid_byte got=%h fs=%0d want 40/1", b, fs_cnt); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_back_to_back();
      test_barrier();
      test_power_off();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
